deserializer: RTL and testbench

//  Serial-to-parallel converter for the FFT datapath: collects PARL_WIDTH serial

---
 rtl/deserializer.sv | 97 +++++++++
 tb/tb_deserializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel converter: gathers PARL_WIDTH samples into one word held behind a
// valid/ready output register. Optional sticky overflow flag under DESERIALIZER_OVF_EN.
module deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PARL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] ser,
    output logic [DATA_WIDTH-1:0] par [PARL_WIDTH],
    output logic                  par_valid,
    input  logic                  par_ready,
    output logic                  busy
`ifdef DESERIALIZER_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int CNT_W = (PARL_WIDTH > 1) ? $clog2(PARL_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PARL_WIDTH - 1);

    logic [CNT_W-1:0]      cnt;
    logic                  dir_q;
    logic [DATA_WIDTH-1:0] stage     [PARL_WIDTH];
    logic [DATA_WIDTH-1:0] word_next [PARL_WIDTH];
    logic                  eff_dir;
    logic [CNT_W-1:0]      slot;
    logic                  complete;
    logic                  out_free;
    logic                  load;

    // Handshake: par transfers on a rising edge with par_valid & par_ready both high;
    // par and par_valid are held unchanged while par_valid=1 and par_ready=0.
    always_comb begin
        eff_dir  = (cnt == '0) ? dir : dir_q;
        slot     = eff_dir ? (LAST - cnt) : cnt;
        complete = en && !clr && (cnt == LAST);
        out_free = !par_valid || par_ready;
        load     = complete && out_free;
        for (int i = 0; i < PARL_WIDTH; i++) begin
            word_next[i] = (CNT_W'(i) == slot) ? ser : stage[i];
        end
    end

    assign busy = (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dir_q     <= 1'b0;
            par_valid <= 1'b0;
            for (int i = 0; i < PARL_WIDTH; i++) begin
                stage[i] <= '0;
                par[i]   <= '0;
            end
        end else begin
            if (clr) begin
                cnt <= '0;
                for (int i = 0; i < PARL_WIDTH; i++) begin
                    stage[i] <= '0;
                end
            end else if (en) begin
                stage[slot] <= ser;
                if (cnt == '0) begin
                    dir_q <= dir;
                end
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            // A completed word that finds the output occupied is dropped.
            if (load) begin
                par_valid <= 1'b1;
                for (int i = 0; i < PARL_WIDTH; i++) begin
                    par[i] <= word_next[i];
                end
            end else if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end
        end
    end

`ifdef DESERIALIZER_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (complete && !out_free) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer (DATA_WIDTH=8, PARL_WIDTH=4): a sample-queue model checked every
// cycle, a delivered-word scoreboard, and hand-computed directed checks.
module tb_deserializer;

  localparam int DW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] ser = '0;
  logic [DW-1:0] par [PW];
  logic          par_valid;
  logic          par_ready = 1'b1;
  logic          busy;
`ifdef DESERIALIZER_OVF_EN
  logic          ovf;
  logic          m_ovf;
`endif

  deserializer #(.DATA_WIDTH(DW), .PARL_WIDTH(PW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .dir(dir),
    .clr(clr),
    .ser(ser),
    .par(par),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .busy(busy)
`ifdef DESERIALIZER_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state: samples of the word in progress, output register, delivered words
  logic [DW-1:0]      cur[$];
  logic               word_dir;
  logic [DW-1:0]      m_word [PW];
  logic               m_valid;
  logic [DW*PW-1:0]   exp_q[$];

  function automatic logic [DW*PW-1:0] pack_par();
    return {par[3], par[2], par[1], par[0]};
  endfunction

  function automatic logic [DW*PW-1:0] pack_model();
    return {m_word[3], m_word[2], m_word[1], m_word[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model update and handshake scoreboard at the active edge (DUT values are pre-edge here)
  always @(posedge clk) begin
    logic [DW-1:0] w [PW];
    logic          acc;
    if (rst) begin
      cur.delete();
      exp_q.delete();
      word_dir = 1'b0;
      m_valid  = 1'b0;
      for (int i = 0; i < PW; i++) m_word[i] = '0;
`ifdef DESERIALIZER_OVF_EN
      m_ovf = 1'b0;
`endif
    end else begin
      if (par_valid && par_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_word: got %h expected no word", pack_par());
        end else begin
          chk("sb_word", pack_par(), exp_q.pop_front());
        end
      end
      acc = m_valid && par_ready;
      if (acc) m_valid = 1'b0;
      if (clr) begin
        cur.delete();
`ifdef DESERIALIZER_OVF_EN
        m_ovf = 1'b0;
`endif
      end else if (en) begin
        if (cur.size() == 0) word_dir = dir;
        cur.push_back(ser);
        if (cur.size() == PW) begin
          for (int k = 0; k < PW; k++) w[word_dir ? PW-1-k : k] = cur[k];
          if (!m_valid) begin
            m_valid = 1'b1;
            for (int i = 0; i < PW; i++) m_word[i] = w[i];
            exp_q.push_back({w[3], w[2], w[1], w[0]});
          end else begin
`ifdef DESERIALIZER_OVF_EN
            m_ovf = 1'b1;
`endif
          end
          cur.delete();
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #2;
    chk("valid", {31'b0, par_valid}, {31'b0, m_valid});
    chk("busy", {31'b0, busy}, {31'b0, (cur.size() != 0)});
    chk("par", pack_par(), pack_model());
`ifdef DESERIALIZER_OVF_EN
    chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
`endif
  end

  task automatic send(input logic [DW-1:0] s, input logic d);
    @(negedge clk);
    en  = 1'b1;
    ser = s;
    dir = d;
    clr = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    en  = 1'b0;
    clr = 1'b0;
    ser = 8'h5a;
  endtask

  initial begin
    logic [DW-1:0] src [PW];
    int nv;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, par_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_par", pack_par(), 32'h0);
    rst = 1'b0;

    // 1: dir=0, single word, one-cycle valid pulse
    send(8'h11, 0); send(8'h22, 0);
    @(negedge clk); en = 1'b1; ser = 8'h33;
    chk("t1_busy", {31'b0, busy}, 32'd1);
    send(8'h44, 0);
    idle();
    chk("t1_valid", {31'b0, par_valid}, 32'd1);
    chk("t1_par", pack_par(), 32'h44332211);
    chk("t1_busy_end", {31'b0, busy}, 32'd0);
    idle();
    chk("t1_pulse", {31'b0, par_valid}, 32'd0);

    // 2: dir latched on first sample, toggles mid-word ignored
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 0); send(8'h44, 0);
    idle();
    chk("t2_par", pack_par(), 32'h11223344);

    // 3: continuous 12 samples -> three words
    nv = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (par_valid) nv++;
      en = 1'b1; ser = DW'(i); dir = 1'b0;
    end
    idle();
    if (par_valid) nv++;
    chk("t3_words", nv, 3);
    chk("t3_par", pack_par(), 32'h0c0b0a09);

    // 3b: held word A, then B completes on the edge that accepts A -> no bubble
    @(negedge clk); par_ready = 1'b0;
    send(8'h21, 0); send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0);
    chk("t3b_hold", pack_par(), 32'h24232221);
    send(8'h34, 0); par_ready = 1'b1;
    idle();
    chk("t3b_valid", {31'b0, par_valid}, 32'd1);
    chk("t3b_par", pack_par(), 32'h34333231);
    idle();

    // 4: output stalled, second word dropped
    par_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(DW'(i), 0);
    idle();
    chk("t4_valid", {31'b0, par_valid}, 32'd1);
    chk("t4_par", pack_par(), 32'h04030201);
`ifdef DESERIALIZER_OVF_EN
    chk("t4_ovf", {31'b0, ovf}, 32'd1);
`endif
    par_ready = 1'b1;
    idle();
    chk("t4_drain", {31'b0, par_valid}, 32'd0);
    @(negedge clk); clr = 1'b1;
    idle();
`ifdef DESERIALIZER_OVF_EN
    chk("t4_ovf_clr", {31'b0, ovf}, 32'd0);
`endif

    // 5: enable gaps, then clr in the middle of a word
    send(8'h11, 0); idle(); idle(); send(8'h22, 0); send(8'h33, 0); idle(); send(8'h44, 0);
    idle();
    chk("t5_gaps", pack_par(), 32'h44332211);
    send(8'haa, 0); send(8'hbb, 0);
    @(negedge clk); clr = 1'b1; en = 1'b1; ser = 8'hcc;
    idle();
    chk("t5_clr_busy", {31'b0, busy}, 32'd0);
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
    idle();
    chk("t5_par", pack_par(), 32'h88776655);

    // 6: reset mid-word, then a loopback word serialized with dir=1
    send(8'h11, 0); send(8'h22, 0);
    @(negedge clk); en = 1'b0; rst = 1'b1;
    #1;
    chk("t6_rst_par", pack_par(), 32'h0);
    chk("t6_rst_valid", {31'b0, par_valid}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    src[0] = 8'hde; src[1] = 8'had; src[2] = 8'hbe; src[3] = 8'hef;
    for (int k = 0; k < PW; k++) send(src[PW-1-k], 1);
    idle();
    chk("t6_loopback", pack_par(), {src[3], src[2], src[1], src[0]});

    repeat (3) idle();
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
